// File: rtl/rsa_modexp_core_pkg.sv
// rsa_modexp_core shared definitions: RAM map, frame header, engine states.
package rsa_modexp_core_pkg;

    localparam int ADDR_XBAR = 0;
    localparam int ADDR_MBAR = 1;
    localparam int ADDR_B    = 2;
    localparam int ADDR_N    = 3;

    localparam int HDR_LEN   = 2;
    localparam int NUM_WORDS = 4;

    typedef logic [2:0] eng_state_t;

    localparam eng_state_t ST_IDLE  = 3'd0;
    localparam eng_state_t ST_LOAD  = 3'd1;
    localparam eng_state_t ST_SQR   = 3'd2;
    localparam eng_state_t ST_MUL   = 3'd3;
    localparam eng_state_t ST_FINAL = 3'd4;
    localparam eng_state_t ST_DONE  = 3'd5;

    // Frame word order maps onto the RAM slots.
    function automatic int word_addr(input logic [1:0] idx);
        int a;
        unique case (idx)
            2'd0:    a = ADDR_XBAR;
            2'd1:    a = ADDR_MBAR;
            2'd2:    a = ADDR_B;
            default: a = ADDR_N;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bram.sv
// Operand RAM: two write ports (port 1 wins on collision), one registered read.
module bram #(
    parameter int ABITS = 8,
    parameter int DBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we1_i,
    input  logic [ABITS-1:0] waddr1_i,
    input  logic [DBITS-1:0] wdata1_i,
    input  logic             we2_i,
    input  logic [ABITS-1:0] waddr2_i,
    input  logic [DBITS-1:0] wdata2_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DBITS-1:0] rdata_o
);

    logic [DBITS-1:0] mem [2**ABITS];
    logic [DBITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we2_i && !(we1_i && (waddr1_i == waddr2_i))) begin
            mem[waddr2_i] <= wdata2_i;
        end
        if (we1_i) begin
            mem[waddr1_i] <= wdata1_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mon_exp.sv
// Exponent sequencer: left-to-right square-and-multiply over Montgomery products.
module mon_exp
    import rsa_modexp_core_pkg::*;
#(
    parameter int N     = 16,
    parameter int NLOG2 = 4,
    parameter int ABITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [N-1:0]     e_i,
    input  logic [NLOG2-1:0] e_idx_i,
    input  logic [NLOG2:0]   k_i,
    input  logic [N-1:0]     n_i,
    input  logic [N-1:0]     rdata_i,
    output logic [ABITS-1:0] raddr_o,
    output logic             we_o,
    output logic [ABITS-1:0] waddr_o,
    output logic [N-1:0]     wdata_o,
    output logic             done_o,
    output logic [N-1:0]     ans_o
);

    eng_state_t       state_q, state_d;
    logic [1:0]       lcnt_q, lcnt_d;
    logic [NLOG2-1:0] bit_q, bit_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     ans_q, ans_d;
    logic             mps_q, mps_d;
    logic [N-1:0]     mp_b;
    logic [N-1:0]     mp_t;
    logic             mp_done;

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        bit_d   = bit_q;
        a_d     = a_q;
        m_d     = m_q;
        ans_d   = ans_q;
        mps_d   = 1'b0;
        we_o    = 1'b0;
        raddr_o = lcnt_q[0] ? ABITS'(ADDR_MBAR) : ABITS'(ADDR_XBAR);
        waddr_o = ABITS'(ADDR_B);
        wdata_o = mp_t;
        mp_b    = (state_q == ST_SQR) ? a_q :
                  (state_q == ST_MUL) ? m_q : N'(1);
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    lcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                // Read data trails the address by one cycle.
                lcnt_d = lcnt_q + 2'd1;
                if (lcnt_q == 2'd1) begin
                    a_d = rdata_i;
                end
                if (lcnt_q == 2'd2) begin
                    m_d     = rdata_i;
                    bit_d   = e_idx_i;
                    mps_d   = 1'b1;
                    state_d = (e_i == '0) ? ST_FINAL : ST_SQR;
                end
            end
            ST_SQR: begin
                if (mp_done) begin
                    a_d   = mp_t;
                    we_o  = 1'b1;
                    mps_d = 1'b1;
                    if (e_i[bit_q]) begin
                        state_d = ST_MUL;
                    end else if (bit_q == '0) begin
                        state_d = ST_FINAL;
                    end else begin
                        bit_d = bit_q - NLOG2'(1);
                    end
                end
            end
            ST_MUL: begin
                if (mp_done) begin
                    a_d   = mp_t;
                    we_o  = 1'b1;
                    mps_d = 1'b1;
                    if (bit_q == '0) begin
                        state_d = ST_FINAL;
                    end else begin
                        bit_d   = bit_q - NLOG2'(1);
                        state_d = ST_SQR;
                    end
                end
            end
            ST_FINAL: begin
                if (mp_done) begin
                    ans_d   = mp_t;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lcnt_q  <= '0;
            bit_q   <= '0;
            a_q     <= '0;
            m_q     <= '0;
            ans_q   <= '0;
            mps_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            bit_q   <= bit_d;
            a_q     <= a_d;
            m_q     <= m_d;
            ans_q   <= ans_d;
            mps_q   <= mps_d;
        end
    end

    mon_pro #(
        .N     (N),
        .NLOG2 (NLOG2)
    ) u_mon_pro (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mps_q),
        .k_i     (k_i),
        .a_i     (a_q),
        .b_i     (mp_b),
        .n_i     (n_i),
        .done_o  (mp_done),
        .t_o     (mp_t)
    );

    assign done_o = (state_q == ST_DONE);
    assign ans_o  = ans_q;

endmodule

// File: rtl/mon_pro.sv
// Bit-serial radix-2 Montgomery product: k iterations plus one reduction step.
module mon_pro #(
    parameter int N     = 16,
    parameter int NLOG2 = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [NLOG2:0] k_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic [N-1:0]   n_i,
    output logic           done_o,
    output logic [N-1:0]   t_o
);

    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N+1:0]   t_q, t_d;
    logic [NLOG2:0] cnt_q, cnt_d;
    logic           run_q, run_d;
    logic           done_q, done_d;
    logic [N+2:0]   s1, s2;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        t_d    = t_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        s1     = {1'b0, t_q} + (a_q[0] ? {3'b0, b_q} : '0);
        s2     = s1[0] ? s1 + {3'b0, n_i} : s1;
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            t_d   = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == k_i) begin
                if (t_q >= {2'b0, n_i}) begin
                    t_d = t_q - {2'b0, n_i};
                end
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                t_d   = (N + 2)'(s2 >> 1);
                a_d   = a_q >> 1;
                cnt_d = cnt_q + (NLOG2 + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            t_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            t_q    <= t_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign t_o    = t_q[N-1:0];

endmodule

// File: rtl/serial_to_parallel.sv
// Frame loader: header latch, word assembly into RAM, e MSB encoder.
module serial_to_parallel
    import rsa_modexp_core_pkg::*;
#(
    parameter int N     = 16,
    parameter int NLOG2 = 4,
    parameter int ABITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_byte_i,
    input  logic             eng_done_i,
    output logic             we_o,
    output logic [ABITS-1:0] waddr_o,
    output logic [N-1:0]     wdata_o,
    output logic             tx_valid_o,
    output logic [N-1:0]     e_o,
    output logic [NLOG2-1:0] e_idx_o,
    output logic [NLOG2:0]   k_o,
    output logic [N-1:0]     n_o
);

    localparam int BPW = N / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [1:0]       hdr_q, hdr_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [1:0]       widx_q, widx_d;
    logic [N-1:0]     word_q, word_d;
    logic             busy_q, busy_d;
    logic             we_q, we_d;
    logic [ABITS-1:0] waddr_q, waddr_d;
    logic [N-1:0]     wdata_q, wdata_d;
    logic             last_q, last_d;
    logic             tx_q, tx_d;
    logic [N-1:0]     e_q, e_d;
    logic [N-1:0]     n_q, n_d;
    logic [NLOG2:0]   k_q, k_d;
    logic             accept;
    logic [N-1:0]     shifted;

    always_comb begin
        accept  = rx_valid_i && !busy_q;
        shifted = (word_q << 8) | N'(rx_byte_i);
        hdr_d   = hdr_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        word_d  = word_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        e_d     = e_q;
        n_d     = n_q;
        k_d     = k_q;
        we_d    = 1'b0;
        last_d  = 1'b0;
        tx_d    = we_q && last_q;
        busy_d  = eng_done_i ? 1'b0 : busy_q;
        if (accept) begin
            if (hdr_q == 2'd0) begin
                k_d   = rx_byte_i[NLOG2:0];
                hdr_d = hdr_q + 2'd1;
            end else if (hdr_q == 2'(HDR_LEN - 1)) begin
                e_d   = N'(rx_byte_i);
                hdr_d = hdr_q + 2'd1;
            end else begin
                word_d = shifted;
                if (bcnt_q == BW'(BPW - 1)) begin
                    bcnt_d  = '0;
                    we_d    = 1'b1;
                    waddr_d = ABITS'(word_addr(widx_q));
                    wdata_d = shifted;
                    if (widx_q == 2'(NUM_WORDS - 1)) begin
                        // Lock out the stream until the engine finishes.
                        last_d = 1'b1;
                        busy_d = 1'b1;
                        hdr_d  = '0;
                        widx_d = '0;
                        n_d    = shifted;
                    end else begin
                        widx_d = widx_q + 2'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q   <= '0;
            bcnt_q  <= '0;
            widx_q  <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            tx_q    <= 1'b0;
            e_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            hdr_q   <= hdr_d;
            bcnt_q  <= bcnt_d;
            widx_q  <= widx_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            e_q     <= e_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        e_idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (e_q[i]) begin
                e_idx_o = NLOG2'(i);
            end
        end
    end

    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign tx_valid_o = tx_q;
    assign e_o        = e_q;
    assign k_o        = k_q;
    assign n_o        = n_q;

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA modexp core: byte-stream loader, operand RAM and Montgomery engine.
module rsa_modexp_core #(
    parameter int N     = 16,
    parameter int NLOG2 = 4,
    parameter int ABITS = 8,
    parameter int DBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    output logic             tx_valid,
    output logic [N-1:0]     e,
    output logic [NLOG2-1:0] e_idx,
    output logic [NLOG2:0]   mp_count,
    output logic [N-1:0]     n,
    output logic             done,
    output logic [N-1:0]     ans
);

    logic             ld_we;
    logic [ABITS-1:0] ld_waddr;
    logic [DBITS-1:0] ld_wdata;
    logic             en_we;
    logic [ABITS-1:0] en_waddr;
    logic [DBITS-1:0] en_wdata;
    logic [ABITS-1:0] raddr;
    logic [DBITS-1:0] rdata;

    serial_to_parallel #(
        .N     (N),
        .NLOG2 (NLOG2),
        .ABITS (ABITS)
    ) u_s2p (
        .clk        (clk),
        .rst_n      (rst),
        .rx_valid_i (rx_valid),
        .rx_byte_i  (rx_byte),
        .eng_done_i (done),
        .we_o       (ld_we),
        .waddr_o    (ld_waddr),
        .wdata_o    (ld_wdata),
        .tx_valid_o (tx_valid),
        .e_o        (e),
        .e_idx_o    (e_idx),
        .k_o        (mp_count),
        .n_o        (n)
    );

    bram #(
        .ABITS (ABITS),
        .DBITS (DBITS)
    ) u_bram (
        .clk      (clk),
        .rst_n    (rst),
        .we1_i    (en_we),
        .waddr1_i (en_waddr),
        .wdata1_i (en_wdata),
        .we2_i    (ld_we),
        .waddr2_i (ld_waddr),
        .wdata2_i (ld_wdata),
        .raddr_i  (raddr),
        .rdata_o  (rdata)
    );

    mon_exp #(
        .N     (N),
        .NLOG2 (NLOG2),
        .ABITS (ABITS)
    ) u_mon_exp (
        .clk     (clk),
        .rst_n   (rst),
        .start_i (tx_valid),
        .e_i     (e),
        .e_idx_i (e_idx),
        .k_i     (mp_count),
        .n_i     (n),
        .rdata_i (rdata),
        .raddr_o (raddr),
        .we_o    (en_we),
        .waddr_o (en_waddr),
        .wdata_o (en_wdata),
        .done_o  (done),
        .ans_o   (ans)
    );

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Randomized bench for rsa_modexp_core against a plain-arithmetic modexp model.
`timescale 1ns/1ps
module tb_rsa_modexp_core;

    localparam int N     = 16;
    localparam int NLOG2 = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             tx_valid;
    logic [N-1:0]     e;
    logic [NLOG2-1:0] e_idx;
    logic [NLOG2:0]   mp_count;
    logic [N-1:0]     n;
    logic             done;
    logic [N-1:0]     ans;

    always #5 clk = ~clk;

    rsa_modexp_core #(
        .N     (N),
        .NLOG2 (NLOG2),
        .ABITS (8),
        .DBITS (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_valid (tx_valid),
        .e        (e),
        .e_idx    (e_idx),
        .mp_count (mp_count),
        .n        (n),
        .done     (done),
        .ans      (ans)
    );

    typedef struct {
        longint e;
        longint eidx;
        longint k;
        longint n;
        longint ans;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [7:0] fr[10];
    int         checks = 0;
    int         failures = 0;
    int         tx_cnt = 0;
    int         done_cnt = 0;
    int         exp_tx = 0;
    int         exp_done = 0;
    longint     cyc = 0;
    longint     tx_cyc = 0;
    longint     bound = 0;
    bit         pending = 0;
    longint     last_ans = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic longint modexp(longint m, longint ex, longint md);
        longint r = 1;
        longint b = m % md;
        longint x = ex;
        while (x != 0) begin
            if (x % 2 == 1) r = (r * b) % md;
            b = (b * b) % md;
            x = x / 2;
        end
        return r % md;
    endfunction

    function automatic longint msb_of(longint x);
        longint p = 0;
        while ((x >> (p + 1)) != 0) p++;
        return p;
    endfunction

    // Operands handed in already in the Montgomery domain: X_bar=R mod n, M_bar=mR mod n.
    task automatic build(input longint k, input longint ev, input longint nv,
                         input longint m, input longint bv);
        longint xb;
        longint mb;
        xb = (longint'(1) << k) % nv;
        mb = (m << k) % nv;
        fr[0] = 8'(k);
        fr[1] = 8'(ev);
        fr[2] = 8'(xb >> 8);
        fr[3] = 8'(xb);
        fr[4] = 8'(mb >> 8);
        fr[5] = 8'(mb);
        fr[6] = 8'(bv >> 8);
        fr[7] = 8'(bv);
        fr[8] = 8'(nv >> 8);
        fr[9] = 8'(nv);
        cur.e    = ev;
        cur.eidx = msb_of(ev);
        cur.k    = k;
        cur.n    = nv;
        cur.ans  = modexp(m, ev, nv);
    endtask

    task automatic send_frame(input bit gaps, input bit hold);
        int g;
        exp_q.push_back(cur);
        exp_tx++;
        for (int i = 0; i < 10; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 3));
                repeat (g) begin
                    @(negedge clk);
                    rx_valid = 1'b0;
                    rx_byte  = 8'($urandom);
                end
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte  = fr[i];
        end
        @(negedge clk);
        if (hold) rx_byte = 8'h4d;
        else rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        rx_valid = 1'b0;
        chk({name, "_done_seen"}, longint'(seen), 1);
        exp_done++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx_valid"}, longint'(tx_valid), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_ans"}, longint'(ans), 0);
        chk({tag, "_e"}, longint'(e), 0);
        chk({tag, "_e_idx"}, longint'(e_idx), 0);
        chk({tag, "_mp_count"}, longint'(mp_count), 0);
        chk({tag, "_n"}, longint'(n), 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            pending = 0;
            last_ans = 0;
        end else begin
            if (pending && !done && (cyc - tx_cyc > bound)) begin
                checks++;
                failures++;
                $display("FAIL done_timeout actual=%0d cycles required<=%0d", cyc - tx_cyc, bound);
                pending = 0;
            end
            if (tx_valid) begin
                tx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx actual=1 required=0");
                end else begin
                    chk("e", longint'(e), exp_q[0].e);
                    chk("e_idx", longint'(e_idx), exp_q[0].eidx);
                    chk("mp_count", longint'(mp_count), exp_q[0].k);
                    chk("n", longint'(n), exp_q[0].n);
                    pending = 1;
                    tx_cyc  = cyc;
                    bound   = (2 * (exp_q[0].eidx + 1) + 1) * (exp_q[0].k + 4) + 4;
                end
            end
            if (done) begin
                done_cnt++;
                if (!pending || exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    chk("ans", longint'(ans), exp_q[0].ans);
                    checks++;
                    if (cyc - tx_cyc > bound) begin
                        failures++;
                        $display("FAIL latency actual=%0d required<=%0d", cyc - tx_cyc, bound);
                    end
                    last_ans = exp_q[0].ans;
                    void'(exp_q.pop_front());
                    pending = 0;
                end
            end else begin
                chk("ans_hold", longint'(ans), last_ans);
            end
        end
    end

    initial begin
        longint k;
        longint nv;
        longint m;
        bit     seen;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        build(10, 8, 589, 199, 16'h012c);
        send_frame(0, 0);
        wait_done("ref_e8");
        chk("ref_e8_ans_lit", longint'(ans), 16'h0083);
        chk("ref_e8_eidx_lit", longint'(e_idx), 3);

        build(10, 1, 589, 199, 16'h012c);
        send_frame(0, 0);
        wait_done("ref_e1");
        chk("ref_e1_ans_lit", longint'(ans), 16'h00c7);

        build(10, 0, 589, 199, 16'h012c);
        send_frame(0, 0);
        wait_done("ref_e0");
        chk("ref_e0_ans_lit", longint'(ans), 1);
        chk("ref_e0_eidx_lit", longint'(e_idx), 0);

        build(10, 8, 589, 1, 16'h012c);
        send_frame(0, 0);
        wait_done("m1");
        chk("m1_ans_lit", longint'(ans), 1);

        build(10, 8, 589, 0, 16'h012c);
        send_frame(0, 0);
        wait_done("m0");
        chk("m0_ans_lit", longint'(ans), 0);

        build(10, 8, 589, 199, 16'h012c);
        send_frame(1, 1);
        wait_done("hold_gaps");
        chk("hold_gaps_ans_lit", longint'(ans), 16'h0083);

        // Partial frame then reset: nothing of it may survive.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte  = fr[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        build(10, 8, 589, 199, 16'h012c);
        send_frame(0, 0);
        wait_done("after_partial");
        chk("after_partial_ans_lit", longint'(ans), 16'h0083);

        // Reset during computation.
        build(10, 8, 589, 199, 16'h012c);
        send_frame(0, 0);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        chk("abort_tx_seen", longint'(seen), 1);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("abort_no_done", longint'(seen), 0);

        build(10, 8, 589, 199, 16'h012c);
        send_frame(0, 0);
        wait_done("b2b_a");
        chk("b2b_a_ans_lit", longint'(ans), 16'h0083);
        build(10, 1, 589, 199, 16'h012c);
        send_frame(0, 0);
        wait_done("b2b_b");
        chk("b2b_b_ans_lit", longint'(ans), 16'h00c7);

        for (int t = 0; t < 16; t++) begin
            k  = longint'($urandom_range(2, 16));
            nv = longint'($urandom_range(1, (32'd1 << k) - 1)) | 1;
            if (nv < 3) nv = 3;
            m  = longint'($urandom_range(0, 32'(nv - 1)));
            build(k, longint'($urandom_range(0, 255)), nv, m, longint'($urandom_range(0, 65535)));
            send_frame(1'($urandom), 1'($urandom));
            wait_done("rand");
        end

        repeat (5) @(negedge clk);
        chk("tx_count", longint'(tx_cnt), longint'(exp_tx));
        chk("done_count", longint'(done_cnt), longint'(exp_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
